// File: rtl/tx_resp_sched.sv
// tx_resp_sched: queues register-read and ALU responses and hands them out
// as held bytes toward the UART TX synchronizer. The handoff paces itself
// on the synchronized busy_tx handshake and gives up after a timeout.
module tx_resp_sched #(
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clck,
  input  logic        rst,
  input  logic [7:0]  rd_data,
  input  logic        rd_vld,
  input  logic [15:0] alu_out,
  input  logic        alu_vld,
  input  logic        busy_tx,
  output logic [7:0]  fsm_out,
  output logic        fsm_valid,
  output logic        sched_busy,
  output logic        drop,
  output logic        tx_timeout
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_SEND      = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);
  localparam logic [7:0] TO_LIMIT  = 8'(TIMEOUT);

  logic [1:0]  r_state;
  logic        r_busy_m;
  logic        r_busy_s;
  logic [7:0]  r_rd_data;
  logic        r_rd_pend;
  logic [15:0] r_alu_data;
  logic        r_alu_pend;
  logic        r_rr_alu;
  logic [7:0]  r_out;
  logic        r_valid;
  logic [3:0]  r_hold;
  logic [7:0]  r_wait;
  logic [7:0]  r_msb;
  logic        r_msb_pend;
  logic        r_drop;
  logic        r_timeout;

  logic        w_grant_rd;
  logic        w_grant_alu;
  logic [7:0]  w_wait_nx;

  assign fsm_out    = r_out;
  assign fsm_valid  = r_valid;
  assign drop       = r_drop;
  assign tx_timeout = r_timeout;
  assign sched_busy = r_rd_pend | r_alu_pend | (r_state != S_IDLE);
  assign w_wait_nx  = r_wait + 8'd1;

  // Two-flop synchronizer for the asynchronous UART busy flag
  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      r_busy_m <= 1'b0;
      r_busy_s <= 1'b0;
    end else begin
      r_busy_m <= busy_tx;
      r_busy_s <= r_busy_m;
    end
  end

  // Grant selection: only in IDLE; round-robin when both slots are pending
  always_comb begin
    w_grant_rd  = 1'b0;
    w_grant_alu = 1'b0;
    if (r_state == S_IDLE) begin
      if (r_rd_pend && r_alu_pend) begin
        w_grant_alu = r_rr_alu;
        w_grant_rd  = !r_rr_alu;
      end else begin
        w_grant_rd  = r_rd_pend;
        w_grant_alu = r_alu_pend;
      end
    end
  end

  // Round-robin pointer; it only flips on a contested grant, so an
  // uncontested grant does not disturb whose turn the next tie is
  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      r_rr_alu <= 1'b1;
    end else if (r_rd_pend && r_alu_pend && (r_state == S_IDLE)) begin
      r_rr_alu <= !r_rr_alu;
    end
  end

  // RD holding slot: a busy slot keeps its old data unless granted this cycle
  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
      r_rd_pend <= 1'b0;
    end else if (rd_vld) begin
      if (!r_rd_pend || w_grant_rd) begin
        r_rd_data <= rd_data;
        r_rd_pend <= 1'b1;
      end
    end else if (w_grant_rd) begin
      r_rd_pend <= 1'b0;
    end
  end

  // ALU holding slot: same load/keep rule as the RD slot
  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      r_alu_data <= '0;
      r_alu_pend <= 1'b0;
    end else if (alu_vld) begin
      if (!r_alu_pend || w_grant_alu) begin
        r_alu_data <= alu_out;
        r_alu_pend <= 1'b1;
      end
    end else if (w_grant_alu) begin
      r_alu_pend <= 1'b0;
    end
  end

  // Drop pulse for a response that arrived at an occupied, ungranted slot
  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= (rd_vld  && r_rd_pend  && !w_grant_rd) ||
                (alu_vld && r_alu_pend && !w_grant_alu);
    end
  end

  // Byte handoff FSM: hold the byte, await busy rise, await busy fall
  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_out      <= '0;
      r_valid    <= 1'b0;
      r_hold     <= '0;
      r_wait     <= '0;
      r_msb      <= '0;
      r_msb_pend <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_rd || w_grant_alu) begin
            r_state <= S_SEND;
            r_valid <= 1'b1;
            r_hold  <= '0;
            if (w_grant_alu) begin
              r_out      <= r_alu_data[7:0];
              r_msb      <= r_alu_data[15:8];
              r_msb_pend <= 1'b1;
            end else begin
              r_out <= r_rd_data;
            end
          end
        end
        S_SEND: begin
          if (r_hold == HOLD_LAST) begin
            r_valid <= 1'b0;
            r_wait  <= '0;
            r_state <= S_WAIT_BUSY;
          end else begin
            r_hold <= r_hold + 4'd1;
          end
        end
        S_WAIT_BUSY: begin
          if (r_busy_s) begin
            r_state <= S_WAIT_DONE;
          end else if (w_wait_nx == TO_LIMIT) begin
            // Treat the byte as sent; WAIT_DONE then proceeds normally
            r_timeout <= 1'b1;
            r_state   <= S_WAIT_DONE;
          end else begin
            r_wait <= w_wait_nx;
          end
        end
        S_WAIT_DONE: begin
          if (!r_busy_s) begin
            if (r_msb_pend) begin
              r_state    <= S_SEND;
              r_out      <= r_msb;
              r_valid    <= 1'b1;
              r_hold     <= '0;
              r_msb_pend <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
